// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//   Operand/result bundle for the bit-serial subtractor.
//   Ports (through modports):
//     start      master->slave  load request, honoured only while idle
//     a, b       master->slave  minuend / subtrahend, WIDTH bits
//     borrow_in  master->slave  initial borrow
//     busy       slave->master  operation in flight (shifting or presenting)
//     done       slave->master  one-cycle pulse, diff/borrow valid
//     diff       slave->master  registered difference, WIDTH bits
//     borrow     slave->master  registered borrow-out
//   WIDTH must match the WIDTH of the attached serial_subtractor.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: diff = a - b - borrow_in (mod 2^WIDTH),
//   one bit per clock, LSB first, using a single full-subtractor cell and a
//   borrow flip-flop.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of serial_subtractor_if (start, a, b, borrow_in in;
//            busy, done, diff, borrow out)
//   Timing: start accepted at edge E0 in IDLE; WIDTH SHIFT cycles follow;
//   done is high in the cycle after edge E0+WIDTH; one op per WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt_r;
  logic             br_r;
  logic             busy_r;
  logic             done_r;
  logic             borrow_r;

  logic             d_s;
  logic             br_nxt_s;
  logic [WIDTH-1:0] res_nxt_s;

  // Full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fs_cell(input logic ai, input logic bi, input logic br);
    logic d;
    logic bo;
    d  = ai ^ bi ^ br;
    bo = (~ai & bi) | (~(ai ^ bi) & br);
    return {bo, d};
  endfunction

  // Current bit's difference and borrow, plus the result reg after shifting d in.
  always_comb begin
    d_s       = 1'b0;
    br_nxt_s  = 1'b0;
    {br_nxt_s, d_s} = fs_cell(a_r[0], b_r[0], br_r);
    res_nxt_s = {d_s, res_r[WIDTH-1:1]};
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      res_r    <= {WIDTH{1'b0}};
      diff_r   <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      br_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      borrow_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            br_r    <= bus.borrow_in;
            res_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= SHIFT;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end

        SHIFT: begin
          a_r   <= {1'b0, a_r[WIDTH-1:1]};
          b_r   <= {1'b0, b_r[WIDTH-1:1]};
          res_r <= res_nxt_s;
          br_r  <= br_nxt_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            // Publish straight from the cell so diff never shows partial results.
            diff_r   <= res_nxt_s;
            borrow_r <= br_nxt_s;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else begin
            done_r   <= 1'b0;
            state_r  <= SHIFT;
          end
        end

        DONE: begin
          // start seen here is dropped; a new op needs IDLE.
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.diff   = diff_r;
  assign bus.borrow = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench: an 8-bit instance for directed vectors, random ops,
//   start-while-busy and mid-op reset; a 4-bit instance for an exhaustive
//   back-to-back sweep. Expected results come from plain unsigned arithmetic.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  logic clk;
  logic rst_n;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(4)) bus4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;
  logic [7:0] last_diff;
  logic       last_borrow;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       borrow;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {8'd0, c};
  endfunction

  function automatic logic [4:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {4'd0, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Full 8-bit operation from an idle DUT, checking latency and result.
  task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb_b, input logic tbin,
                        input logic [7:0] ediff, input logic eborrow, input string name);
    int  lat;
    bit  got;
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = ta; bus8.b = tb_b; bus8.borrow_in = tbin;
    @(posedge clk); #1;
    bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.borrow_in = 1'($urandom);
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (bus8.done) got = 1'b1;
    end
    check({name, "_latency"}, 32'(lat), 32'd9);
    check({name, "_diff"}, 32'(bus8.diff), 32'(ediff));
    check({name, "_borrow"}, 32'(bus8.borrow), 32'(eborrow));
    last_diff   = ediff;
    last_borrow = eborrow;
  endtask

  initial begin
    logic [8:0] r9;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    int         bad_iv;
    int         n_done;

    n_checks = 0; n_pass = 0;
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b0};
    vecs[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};

    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = 8'd0; bus8.b = 8'd0; bus8.borrow_in = 1'b0;
    bus4.start = 1'b0; bus4.a = 4'd0; bus4.b = 4'd0; bus4.borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_diff", 32'(bus8.diff), 32'd0);
    check("rst_borrow", 32'(bus8.borrow), 32'd0);
    check("rst4_busy", 32'(bus4.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 6; i++)
      do_op8(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].borrow, $sformatf("vec%0d", i));

    // Random operations against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      r9 = ref8(ra, rb, rc);
      do_op8(ra, rb, rc, r9[7:0], r9[8], $sformatf("rnd%0d", i));
    end

    // start re-pulsed while busy and in the done cycle must be ignored.
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = 8'h05; bus8.b = 8'h03; bus8.borrow_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      bus8.start = (k == 3 || k == 9) ? 1'b1 : 1'b0;
      bus8.a = 8'hFF; bus8.b = 8'h00;
      @(negedge clk);
      check($sformatf("busy_c%0d", k), 32'(bus8.busy), (k <= 9) ? 32'd1 : 32'd0);
      check($sformatf("done_c%0d", k), 32'(bus8.done), (k == 9) ? 32'd1 : 32'd0);
      check($sformatf("diff_c%0d", k), 32'(bus8.diff), (k >= 9) ? 32'h02 : 32'(last_diff));
    end
    bus8.start = 1'b0;
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) n_done++;
    end
    check("ignored_start_no_done", 32'(n_done), 32'd0);
    check("ignored_start_diff_hold", 32'(bus8.diff), 32'h02);
    last_diff = 8'h02; last_borrow = 1'b0;

    // Reset in cycle 4 of an operation aborts it.
    @(posedge clk); #1;
    bus8.start = 1'b1; bus8.a = 8'hC3; bus8.b = 8'h41; bus8.borrow_in = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus8.busy), 32'd0);
    check("abort_done", 32'(bus8.done), 32'd0);
    check("abort_diff", 32'(bus8.diff), 32'd0);
    check("abort_borrow", 32'(bus8.borrow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done) n_done++;
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    check("abort_idle_busy", 32'(bus8.busy), 32'd0);
    do_op8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, "after_abort");

    // WIDTH=4 exhaustive sweep with start held high (back-to-back).
    bad_iv = 0;
    @(posedge clk); #1;
    bus4.a = 4'd0; bus4.b = 4'd0; bus4.borrow_in = 1'b0; bus4.start = 1'b1;
    for (int idx = 0; idx < 512; idx++) begin
      int         waited;
      bit         got;
      logic [8:0] iv;
      logic [4:0] exp5;
      iv = 9'(idx);
      waited = 0; got = 1'b0;
      while (!got && waited < 16) begin
        @(negedge clk);
        waited++;
        if (bus4.done) got = 1'b1;
      end
      if (!got) begin
        check($sformatf("w4_timeout_%0d", idx), 32'd0, 32'd1);
        break;
      end
      exp5 = ref4(iv[3:0], iv[7:4], iv[8]);
      check($sformatf("w4_a%0d_b%0d_c%0d", iv[3:0], iv[7:4], iv[8]),
            32'({bus4.borrow, bus4.diff}), 32'(exp5));
      if (idx > 0 && waited != 6) bad_iv++;
      if (idx < 511) begin
        iv = 9'(idx + 1);
        bus4.a = iv[3:0]; bus4.b = iv[7:4]; bus4.borrow_in = iv[8];
      end
    end
    bus4.start = 1'b0;
    check("w4_throughput_bad_intervals", 32'(bad_iv), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
